// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled serial receiver (1 start, DATA_BITS data LSB first, 1 stop).
// Presents each good word on RxData with a one-cycle RxD_done pulse and flags
// framing errors with a one-cycle RxD_ferr pulse.
// Optional build macro UART_RX_SYNC_EN: routes Rxd through a two-flop PCLK
// synchronizer (reset to 1) before any sampling logic.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | line idle, counters cleared, waiting for a tick with Rxd low
// START | counting to mid start bit; high there means glitch -> IDLE
// DATA  | sampling each data bit at mid bit, shifting in LSB first
// STOP  | first tick with Rxd high accepts the frame; OVERSAMPLE low ticks -> ferr
module uart_rx #(
  parameter int DATA_BITS  = 32,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  input  logic                 tick,
  input  logic                 Rxd,
  output logic [DATA_BITS-1:0] RxData,
  output logic                 RxD_done,
  output logic                 RxD_ferr,
  output logic                 RxBusy
);

  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int CW = $clog2(OVERSAMPLE);

  localparam logic [CW-1:0] HALF_M1  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic [DATA_BITS-1:0] shift;
  logic                 rx;

  // Decoded per-cycle controls from the output process
  logic cnt_clr;
  logic cnt_inc;
  logic idx_clr;
  logic idx_inc;
  logic sample_bit;
  logic done_nxt;
  logic ferr_nxt;

`ifdef UART_RX_SYNC_EN
  logic [1:0] rx_sync;

  // Two-flop synchronizer; resets to the idle line level so reset never looks like a start bit
  always_ff @(posedge PCLK) begin
    if (PRESET) rx_sync <= 2'b11;
    else        rx_sync <= {rx_sync[0], Rxd};
  end

  assign rx = rx_sync[1];
`else
  assign rx = Rxd;
`endif

  // State register
  always_ff @(posedge PCLK) begin
    if (PRESET) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode; every transition is tick-qualified
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (tick && !rx) state_nxt = S_START;
      end
      S_START: begin
        if (tick && (cnt == HALF_M1)) state_nxt = rx ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (tick && (cnt == FULL_M1) && (idx == LAST_IDX)) state_nxt = S_STOP;
      end
      S_STOP: begin
        if (tick && (rx || (cnt == FULL_M1))) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output/control decode for counters, shifter and result pulses
  always_comb begin
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    idx_clr    = 1'b0;
    idx_inc    = 1'b0;
    sample_bit = 1'b0;
    done_nxt   = 1'b0;
    ferr_nxt   = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_clr = 1'b1;
        idx_clr = 1'b1;
      end
      S_START: begin
        if (tick) begin
          if (cnt == HALF_M1) cnt_clr = 1'b1;
          else                cnt_inc = 1'b1;
        end
      end
      S_DATA: begin
        if (tick) begin
          if (cnt == FULL_M1) begin
            cnt_clr    = 1'b1;
            sample_bit = 1'b1;
            if (idx != LAST_IDX) idx_inc = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      S_STOP: begin
        // A stop bit may be a single tick long, so the first high tick wins
        if (tick) begin
          if (rx)                   done_nxt = 1'b1;
          else if (cnt == FULL_M1)  ferr_nxt = 1'b1;
          else                      cnt_inc  = 1'b1;
        end
      end
      default: begin
        cnt_clr = 1'b1;
        idx_clr = 1'b1;
      end
    endcase
  end

  // Tick counter and bit index
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + CW'(1);
      if (idx_clr)      idx <= '0;
      else if (idx_inc) idx <= idx + IW'(1);
    end
  end

  // Shift register: new bit enters at the MSB so the first bit ends in bit 0
  always_ff @(posedge PCLK) begin
    if (PRESET)          shift <= '0;
    else if (sample_bit) shift <= {rx, shift[DATA_BITS-1:1]};
  end

  // Registered result word and pulses; a framing error leaves RxData untouched
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      RxData   <= '0;
      RxD_done <= 1'b0;
      RxD_ferr <= 1'b0;
    end else begin
      RxD_done <= done_nxt;
      RxD_ferr <= ferr_nxt;
      if (done_nxt) RxData <= shift;
    end
  end

  assign RxBusy = (state != S_IDLE) && !PRESET;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized line stimulus at tick granularity, checked against a
// frame-level reference model that scans the tick-sampled line for frames.
module tb_uart_rx;
  localparam int DB = 32;
  localparam int OS = 16;
  localparam int H  = OS / 2;

  logic          PCLK   = 1'b0;
  logic          PRESET = 1'b1;
  logic          tick   = 1'b0;
  logic          Rxd    = 1'b1;
  logic [DB-1:0] RxData;
  logic          RxD_done;
  logic          RxD_ferr;
  logic          RxBusy;

  int n_checks = 0;
  int n_errors = 0;
  int tick_num = 0;

  typedef struct {
    logic [1:0]  kind;     // {ferr, done}
    logic [31:0] data;
    int          tk;
    logic        on_tick;
    logic        busy;
  } ev_t;

  ev_t         got_q[$];
  ev_t         exp_q[$];
  ev_t         mon_e;
  logic        line_q[$];
  logic [31:0] good;

  uart_rx #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .tick    (tick),
    .Rxd     (Rxd),
    .RxData  (RxData),
    .RxD_done(RxD_done),
    .RxD_ferr(RxD_ferr),
    .RxBusy  (RxBusy)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: record every result pulse, sampled 1 ns after the edge
  initial forever begin
    @(posedge PCLK);
    #1;
    if (!PRESET && (RxD_done || RxD_ferr)) begin
      mon_e.kind    = {RxD_ferr, RxD_done};
      mon_e.data    = RxData;
      mon_e.tk      = tick_num;
      mon_e.on_tick = tick;
      mon_e.busy    = RxBusy;
      got_q.push_back(mon_e);
    end
  end

  task automatic add_level(input logic v, input int n);
    for (int i = 0; i < n; i++) line_q.push_back(v);
  endtask

  task automatic add_frame(input logic [31:0] d, input logic stop_val, input int stop_len);
    add_level(1'b0, OS);
    for (int b = 0; b < DB; b++) add_level(d[b], OS);
    add_level(stop_val, stop_len);
  endtask

  // Reference: scan the per-tick line for start, mid-start check, mid-bit data
  // samples and the stop window; emit expected result events by tick index.
  task automatic run_model(inout logic [31:0] last_good);
    int          n;
    int          p;
    int          t0;
    int          s;
    int          found;
    logic [31:0] w;
    ev_t         e;
    n = line_q.size();
    p = 0;
    exp_q.delete();
    while (p < n) begin
      if (line_q[p] != 1'b0) begin
        p++;
        continue;
      end
      t0 = p;
      if (t0 + H >= n) break;
      if (line_q[t0 + H]) begin
        p = t0 + H + 1;
        continue;
      end
      if (t0 + H + OS * DB >= n) break;
      for (int k = 0; k < DB; k++) w[k] = line_q[t0 + H + OS * (k + 1)];
      s = t0 + H + OS * DB + 1;
      found = -1;
      for (int j = s; j < s + OS && j < n; j++) begin
        if (line_q[j]) begin
          found = j;
          break;
        end
      end
      e.on_tick = 1'b1;
      e.busy    = 1'b0;
      if (found >= 0) begin
        e.kind = 2'b01; e.data = w; e.tk = found;
        exp_q.push_back(e);
        last_good = w;
        p = found + 1;
      end else if (s + OS - 1 < n) begin
        e.kind = 2'b10; e.data = last_good; e.tk = s + OS - 1;
        exp_q.push_back(e);
        p = s + OS;
      end else begin
        break;
      end
    end
  endtask

  // Each line entry lasts 4 PCLK; the tick pulse is the last of the four
  task automatic drive_stream();
    for (int k = 0; k < line_q.size(); k++) begin
      @(negedge PCLK);
      Rxd  = line_q[k];
      tick = 1'b0;
      repeat (2) @(negedge PCLK);
      @(negedge PCLK);
      tick_num = k;
      tick     = 1'b1;
    end
    @(negedge PCLK);
    tick = 1'b0;
    repeat (4) @(negedge PCLK);
  endtask

  task automatic compare_events(input string tag);
    chk({tag, " count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      chk($sformatf("%s ev%0d kind", tag, i), 64'(got_q[i].kind), 64'(exp_q[i].kind));
      chk($sformatf("%s ev%0d data", tag, i), 64'(got_q[i].data), 64'(exp_q[i].data));
      chk($sformatf("%s ev%0d tick", tag, i), 64'(got_q[i].tk), 64'(exp_q[i].tk));
      chk($sformatf("%s ev%0d latency", tag, i), 64'(got_q[i].on_tick), 64'(exp_q[i].on_tick));
      chk($sformatf("%s ev%0d busy", tag, i), 64'(got_q[i].busy), 64'(exp_q[i].busy));
    end
  endtask

  initial begin
    // Reset held with the line low and tick toggling
    PRESET = 1'b1;
    Rxd    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge PCLK);
      tick = ~tick;
    end
    @(posedge PCLK);
    #1;
    chk("reset data", 64'(RxData), 64'h0);
    chk("reset done", 64'(RxD_done), 64'h0);
    chk("reset ferr", 64'(RxD_ferr), 64'h0);
    chk("reset busy", 64'(RxBusy), 64'h0);
    @(negedge PCLK);
    PRESET = 1'b0;
    tick   = 1'b0;
    Rxd    = 1'b1;
    @(posedge PCLK);
    #1;
    chk("post-reset busy", 64'(RxBusy), 64'h0);

    // Main stream: directed frames, glitch, framing error, random frames
    line_q.delete();
    add_level(1'b1, 8);
    add_frame(32'hA5C3_0F81, 1'b1, OS);
    add_level(1'b1, 4);
    add_frame(32'h0000_0001, 1'b1, 1);
    add_frame(32'hFFFF_FFFE, 1'b1, OS);
    add_level(1'b1, 6);
    add_level(1'b0, 3);
    add_level(1'b1, 20);
    add_frame(32'h1234_5678, 1'b0, OS);
    add_level(1'b1, 20);
    for (int r = 0; r < 6; r++) begin
      add_frame($urandom, 1'b1, $urandom_range(1, OS));
      add_level(1'b1, $urandom_range(0, 3));
    end
    add_level(1'b1, 20);
    good = '0;
    run_model(good);
    got_q.delete();
    drive_stream();
    compare_events("main");
    chk("main final data", 64'(RxData), 64'(good));
    chk("main final busy", 64'(RxBusy), 64'h0);

    // Mid-frame reset during bit 10
    line_q.delete();
    add_level(1'b1, 4);
    add_level(1'b0, OS);
    for (int b = 0; b < 10; b++) add_level(1'(32'hDEAD_BEEF >> b), OS);
    add_level(1'b1, H);
    good = '0;
    run_model(good);
    got_q.delete();
    drive_stream();
    chk("midframe busy", 64'(RxBusy), 64'h1);
    @(negedge PCLK);
    PRESET = 1'b1;
    repeat (2) @(posedge PCLK);
    #1;
    chk("midreset data", 64'(RxData), 64'h0);
    chk("midreset done", 64'(RxD_done), 64'h0);
    chk("midreset ferr", 64'(RxD_ferr), 64'h0);
    chk("midreset busy", 64'(RxBusy), 64'h0);
    @(negedge PCLK);
    PRESET = 1'b0;
    compare_events("partial");

    // Clean frame after the reset
    line_q.delete();
    add_level(1'b1, 4);
    add_frame(32'hDEAD_BEEF, 1'b1, OS);
    add_level(1'b1, 10);
    good = '0;
    run_model(good);
    got_q.delete();
    drive_stream();
    compare_events("after reset");
    chk("after reset data", 64'(RxData), 64'hDEAD_BEEF);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
